dot_product_accumulator: RTL and testbench

//  Downstream stage of the address-generator state machine in the 32x32 matrix datapath.
//  - The generator's address sweep drives the A/B operand RAMs.
//  - This block takes the RAM read data, multiplies each A/B pair, and sums DIM products per output element.
//  - It emits one result per element, tagged with its linear index i*DIM+j, plus an end-of-matrix pulse.

---
 rtl/dot_product_accumulator_if.sv | 38 +++
 rtl/dot_product_accumulator.sv | 138 +++++++++++++
 tb/tb_dot_product_accumulator.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/dot_product_accumulator_if.sv
`default_nettype none
// ============================================================================
//  Module     : dot_product_accumulator_if
//  Description: Operand/result bundle between the address-generator side and
//               the dot-product accumulator (product terms in, tagged results
//               and status out).
//  Revision   : 1.0 - initial release
// ============================================================================
interface dot_product_accumulator_if #(
    parameter int DIM    = 3,
    parameter int DATA_W = 8
) ();
    localparam int ACC_W = 2*DATA_W + $clog2(DIM+1);
    localparam int IDX_W = $clog2(DIM*DIM-1) + 1;

    logic              ena;
    logic              flag_in;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic [ACC_W-1:0]  res;
    logic              res_valid;
    logic [IDX_W-1:0]  res_idx;
    logic              done;
    logic              err;

    // Term source: drives the request strobe, marker and RAM read data.
    modport master (
        output ena, flag_in, a_data, b_data,
        input  res, res_valid, res_idx, done, err
    );

    // Accumulator: consumes terms, produces results and status.
    modport slave (
        input  ena, flag_in, a_data, b_data,
        output res, res_valid, res_idx, done, err
    );
endinterface
`default_nettype wire

// File: rtl/dot_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module     : dot_product_accumulator
//  Description: Multiplies A/B RAM read data pairwise and sums DIM products per
//               output element; emits each result tagged with its linear
//               index, an end-of-matrix pulse and a sticky sweep-marker error.
//               Build option DOTP_SIGNED_EN selects two's-complement operands
//               (default: unsigned).
//  Revision   : 1.0 - initial release
// ============================================================================
module dot_product_accumulator #(
    parameter int DIM    = 3,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    dot_product_accumulator_if.slave  bus
);
    localparam int ACC_W = 2*DATA_W + $clog2(DIM+1);
    localparam int IDX_W = $clog2(DIM*DIM-1) + 1;
    localparam int K_W   = (DIM > 1) ? $clog2(DIM) : 1;

    localparam logic [K_W-1:0]   K_LAST   = K_W'(DIM-1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIM*DIM-1);

    // Operands widened to twice their width so the low half of the
    // multiply is the exact product in either number format.
    logic [2*DATA_W-1:0] w_op_a;
    logic [2*DATA_W-1:0] w_op_b;
    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    w_sum;

`ifdef DOTP_SIGNED_EN
    assign w_op_a     = {{DATA_W{bus.a_data[DATA_W-1]}}, bus.a_data};
    assign w_op_b     = {{DATA_W{bus.b_data[DATA_W-1]}}, bus.b_data};
    assign w_prod     = w_op_a * w_op_b;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
`else
    assign w_op_a     = {{DATA_W{1'b0}}, bus.a_data};
    assign w_op_b     = {{DATA_W{1'b0}}, bus.b_data};
    assign w_prod     = w_op_a * w_op_b;
    assign w_prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, w_prod};
`endif

    logic              r_v1;
    logic              r_v2;
    logic [ACC_W-1:0]  r_prod;
    logic [ACC_W-1:0]  r_acc;
    logic [K_W-1:0]    r_k;
    logic              r_emit;
    logic [ACC_W-1:0]  r_res;
    logic              r_res_valid;
    logic [IDX_W-1:0]  r_idx;
    logic [K_W-1:0]    r_k_in;
    logic [IDX_W-1:0]  r_idx_in;
    logic              r_err;

    // First term of an element loads instead of adding.
    assign w_sum = ((r_k == '0) ? '0 : r_acc) + r_prod;

    // Valid shift and product register (read data arrives one cycle after ena).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_prod <= '0;
        end else begin
            r_v1 <= bus.ena;
            r_v2 <= r_v1;
            if (r_v1) begin
                r_prod <= w_prod_ext;
            end
        end
    end

    // Accumulate terms; on the final term publish the sum and flag emission.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_k    <= '0;
            r_res  <= '0;
            r_emit <= 1'b0;
        end else begin
            r_emit <= 1'b0;
            if (r_v2) begin
                r_acc <= w_sum;
                if (r_k == K_LAST) begin
                    r_res  <= w_sum;
                    r_emit <= 1'b1;
                    r_k    <= '0;
                end else begin
                    r_k <= r_k + 1'b1;
                end
            end
        end
    end

    // Result strobe and element index; index advances after each pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_idx       <= '0;
        end else begin
            r_res_valid <= r_emit;
            if (r_res_valid) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
        end
    end

    // Track the position of each accepted term to vet the end-of-sweep marker.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k_in   <= '0;
            r_idx_in <= '0;
            r_err    <= 1'b0;
        end else if (bus.ena) begin
            if (bus.flag_in && !((r_k_in == K_LAST) && (r_idx_in == IDX_LAST))) begin
                r_err <= 1'b1;
            end
            if (r_k_in == K_LAST) begin
                r_k_in   <= '0;
                r_idx_in <= (r_idx_in == IDX_LAST) ? '0 : r_idx_in + 1'b1;
            end else begin
                r_k_in <= r_k_in + 1'b1;
            end
        end
    end

    assign bus.res       = r_res;
    assign bus.res_valid = r_res_valid;
    assign bus.res_idx   = r_idx;
    assign bus.done      = r_res_valid && (r_idx == IDX_LAST);
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dot_product_accumulator.sv
`default_nettype none
// ============================================================================
//  Module     : tb_dot_product_accumulator
//  Description: Randomised scoreboard bench for dot_product_accumulator
//               (DIM=3, DATA_W=8). Honours DOTP_SIGNED_EN for the model.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_dot_product_accumulator;
    localparam int DIM    = 3;
    localparam int DATA_W = 8;
    localparam int NRES   = DIM*DIM;

    typedef struct {
        logic [17:0] res;
        int          idx;
        bit          done;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    dot_product_accumulator_if #(.DIM(DIM), .DATA_W(DATA_W)) bus ();

    dot_product_accumulator #(.DIM(DIM), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t      sb[$];
    longint    m_sum;
    int        m_terms;
    int        m_idx;
    int        m_n;
    bit        m_err;
    logic [7:0] pend_a, pend_b;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint prod(input logic [7:0] a, input logic [7:0] b);
`ifdef DOTP_SIGNED_EN
        return longint'($signed(a)) * longint'($signed(b));
`else
        return longint'(a) * longint'(b);
`endif
    endfunction

    // Reference: every DIM terms form one element; NRES elements form a matrix.
    task automatic model_term(input logic [7:0] a, input logic [7:0] b,
                              input bit fl, input int edge_no);
        exp_t e;
        if (fl && (m_n % (DIM*NRES)) != DIM*NRES-1) m_err = 1'b1;
        m_n++;
        m_sum += prod(a, b);
        m_terms++;
        if (m_terms == DIM) begin
            e.res  = m_sum[17:0];
            e.idx  = m_idx;
            e.done = (m_idx == NRES-1);
            e.cyc  = edge_no + 3;
            sb.push_back(e);
            m_sum   = 0;
            m_terms = 0;
            m_idx   = (m_idx + 1) % NRES;
        end
    endtask

    // One clock of stimulus; read data for a term follows its ena by a cycle.
    task automatic step(input bit en, input bit fl, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        bus.ena     = en;
        bus.flag_in = fl;
        bus.a_data  = pend_a;
        bus.b_data  = pend_b;
        pend_a = en ? a : 8'($urandom);
        pend_b = en ? b : 8'($urandom);
        if (en) model_term(a, b, fl, cyc + 1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst         = 1'b1;
        bus.ena     = 1'b0;
        bus.flag_in = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
        m_sum = 0; m_terms = 0; m_idx = 0; m_n = 0; m_err = 1'b0;
        sb.delete();
    endtask

    task automatic drain(input string tag);
        repeat (8) step(1'b0, 1'b0, 8'h00, 8'h00);
        check({tag, "_pending"}, sb.size(), 0);
        check({tag, "_err"}, bus.err, m_err);
    endtask

    // Full matrix of constant operands, flag on the final term, optional gaps.
    task automatic matrix_const(input logic [7:0] a, input logic [7:0] b, input int max_gap);
        for (int t = 0; t < DIM*NRES; t++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 8'h00, 8'h00);
            step(1'b1, (t == DIM*NRES-1), a, b);
        end
    endtask

    // Scoreboard monitor: compares every presented result.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.res_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("res", bus.res, e.res);
                    check("res_idx", bus.res_idx, e.idx);
                    check("done", bus.done, e.done);
                    check("latency_edge", cyc, e.cyc);
                end
            end else if (bus.done) begin
                check("done_without_valid", 1, 0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        bus.ena = 1'b0; bus.flag_in = 1'b0; bus.a_data = '0; bus.b_data = '0;
        pend_a = '0; pend_b = '0;
        m_sum = 0; m_terms = 0; m_idx = 0; m_n = 0; m_err = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_res", bus.res, 0);
        check("rst_res_valid", bus.res_valid, 0);
        check("rst_res_idx", bus.res_idx, 0);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b0;

        // 2*3 back-to-back, then all-ones-byte corner, then gapped stream
        matrix_const(8'd2, 8'd3, 0);
        drain("b2b");
        matrix_const(8'hFF, 8'hFF, 0);
        drain("max");
        matrix_const(8'd2, 8'd3, 4);
        drain("gaps");

        // Reset after two terms of index 4 must discard the partial sum
        for (int t = 0; t < 4*DIM+2; t++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        drain("pre_rst");
        do_reset(2);
        matrix_const(8'd1, 8'd1, 0);
        drain("post_rst");

        // Sign-sensitive operands
        for (int t = 0; t < DIM; t++) step(1'b1, 1'b0, 8'hFF, 8'h02);
        drain("sign");

        // Random data, random gaps, marker where the sweep really ends
        for (int t = 0; t < 2*DIM*NRES; t++) begin
            int gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)), 8'h00, 8'h00);
            step(1'b1, (m_n % (DIM*NRES)) == DIM*NRES-1, 8'($urandom), 8'($urandom));
        end
        drain("random");

        // Misplaced marker on the 5th term sets a sticky error
        do_reset(1);
        for (int t = 0; t < DIM*NRES; t++) step(1'b1, (t == 4), 8'($urandom), 8'($urandom));
        drain("flag5");
        check("err_set", bus.err, 1);
        for (int t = 0; t < DIM*NRES; t++) step(1'b1, 1'b0, 8'($urandom), 8'($urandom));
        drain("flag5_sticky");
        check("err_sticky", bus.err, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
